uart_rx_datapath: RTL and testbench

//  UART receiver: deserialises the transmit line back into parallel words.

---
 rtl/uart_rx_datapath.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rx_datapath.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_datapath                                             |
// | Description : UART receiver datapath. Oversampled start-bit detection,     |
// |               mid-bit data sampling, stop-bit check, valid/ready output    |
// |               handshake with framing and overrun error pulses.             |
// |               Optional even-parity bit enabled by UART_RX_PARITY_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_datapath #(
  parameter int WORD_SIZE  = 8,   // data bits per frame
  parameter int OVERSAMPLE = 16,  // sample_tick pulses per bit period (even, >= 4)
  parameter int CNT_WIDTH  = 4    // tick counter width, 2**CNT_WIDTH >= OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 serial_in,
  input  logic                 sample_tick,
  input  logic                 rx_ready,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int BIT_CNT_W = $clog2(WORD_SIZE + 1);

  // Tick count at which the start bit is sampled (its middle) and at which
  // every following bit is sampled (one full bit period later each time).
  localparam logic [CNT_WIDTH-1:0] c_tick_half_last = CNT_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] c_tick_full_last = CNT_WIDTH'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] c_last_bit       = BIT_CNT_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Line synchroniser
  logic                 meta_q;
  logic                 rxs_q;

  // Frame engine
  state_t               state_q,    state_d;
  logic [CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [WORD_SIZE-1:0] shift_q,    shift_d;
  logic                 deliver_q,  deliver_d;   // good stop bit seen, deliver next clk
  logic                 frame_err_d;

`ifdef UART_RX_PARITY_EN
  logic                 par_acc_q,  par_acc_d;   // running XOR of data + parity bits
  logic                 par_bad_q,  par_bad_d;   // parity result of the frame being delivered
  logic                 parity_err_q;
`endif

  // Output stage
  logic [WORD_SIZE-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q;
  logic                 overrun_err_q, overrun_err_d;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= serial_in;
      rxs_q  <= meta_q;
    end
  end

  // Frame engine state registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      deliver_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      deliver_q  <= deliver_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= par_acc_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  // Frame engine next state: everything here moves only on a sample tick.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d   = par_acc_q;
    par_bad_d   = par_bad_q;
`endif

    if (sample_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == c_tick_half_last) begin
            // Middle of the start bit: a high line here was a glitch.
            if (!rxs_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
              par_acc_d  = 1'b0;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_WIDTH'(1);
          end
        end

        S_DATA: begin
          if (tick_cnt_q == c_tick_full_last) begin
            tick_cnt_d = '0;
            // LSB arrives first, so shift right and insert at the MSB.
            shift_d    = {rxs_q, shift_q[WORD_SIZE-1:1]};
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
`ifdef UART_RX_PARITY_EN
            par_acc_d  = par_acc_q ^ rxs_q;
`endif
            if (bit_cnt_q == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_WIDTH'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == c_tick_full_last) begin
            tick_cnt_d = '0;
            par_acc_d  = par_acc_q ^ rxs_q;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_WIDTH'(1);
          end
        end
`endif

        S_STOP: begin
          if (tick_cnt_q == c_tick_full_last) begin
            tick_cnt_d = '0;
            if (rxs_q) begin
              deliver_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              // Even parity: a set accumulator means an odd count of ones.
              par_bad_d = par_acc_q;
`endif
              state_d   = S_IDLE;
            end else begin
              // Bad stop bit: drop the word and wait out the low line.
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_WIDTH'(1);
          end
        end

        S_BREAK: begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output stage next state: deliver a finished word or retire the held one.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    overrun_err_d = 1'b0;

    if (deliver_q) begin
      // A consumer taking the old word this cycle frees the slot for the new one.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Output stage registers and one-clock error pulses.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      // Reported alongside the delivery, even if the word is lost to overrun.
      parity_err_q  <= deliver_q & par_bad_q;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_datapath                                          |
// | Description : Self-checking bench for uart_rx_datapath. Directed frames    |
// |               plus randomized frames compared against a word-level model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_datapath;

  localparam int WS       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          serial_in = 1'b1;
  logic          sample_tick = 1'b0;
  logic          rx_ready = 1'b0;
  logic [WS-1:0] rx_data;
  logic          rx_valid;
  logic          framing_err;
  logic          overrun_err;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Observed events, accumulated by the monitor
  int            n_frame = 0;
  int            n_over  = 0;
  int            n_par   = 0;
  logic [WS-1:0] acc_q[$];

  uart_rx_datapath #(
    .WORD_SIZE (WS),
    .OVERSAMPLE(OS),
    .CNT_WIDTH (4)
  ) u_dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .serial_in  (serial_in),
    .sample_tick(sample_tick),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clock in every TICK_DIV.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = (ph == TICK_DIV - 1);
      ph = (ph + 1) % TICK_DIV;
    end
  end

  // Monitor: record accepted words and count error pulses.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (framing_err) n_frame++;
      if (overrun_err) n_over++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_par++;
`endif
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WS-1:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  initial begin : main
    int            lat;
    bit            seen;
    int            f0, o0, p0;
    logic [WS-1:0] exp_q[$];
    logic          hold_v;
    logic [WS-1:0] hold_d;
    int            exp_frame, exp_over, exp_par;
    logic [WS-1:0] d;
    logic          r, bad, pf;
    int            gap, ph;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_oerr", overrun_err, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_bits(1);

    // ---------------- clean frame 0xA5 with latency window
    rx_ready = 1'b1;
    acc_q.delete();
    f0 = n_frame; o0 = n_over;
    lat = 0; seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (!seen && lat < 2000) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
      end
    join
    idle_bits(1);
    chk("t1_count", acc_q.size(), 1);
    chk("t1_data", acc_q[0], 8'hA5);
    chk("t1_ferr", n_frame - f0, 0);
    chk("t1_oerr", n_over - o0, 0);
    // 2 sync + 9.5 bits + 1 clk, plus up to one tick of detection jitter
    chk("t1_latency_window", (lat >= 609 && lat <= 616), 1);

    // ---------------- false start
    acc_q.delete();
    f0 = n_frame; o0 = n_over;
    serial_in = 1'b0;
    repeat (5 * TICK_DIV) @(posedge clk);
    #1;
    idle_bits(12);
    chk("t2_count", acc_q.size(), 0);
    chk("t2_ferr", n_frame - f0, 0);
    chk("t2_oerr", n_over - o0, 0);

    // ---------------- framing error, long break, then good frame
    acc_q.delete();
    f0 = n_frame; o0 = n_over;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * TICK_DIV) @(posedge clk);
    #1;
    idle_bits(2);
    send_frame(8'h11, 1'b1, 1'b0);
    idle_bits(1);
    chk("t3_ferr", n_frame - f0, 1);
    chk("t3_count", acc_q.size(), 1);
    chk("t3_data", acc_q[0], 8'h11);
    chk("t3_oerr", n_over - o0, 0);

    // ---------------- overrun
    rx_ready = 1'b0;
    acc_q.delete();
    o0 = n_over;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    idle_bits(1);
    @(negedge clk);
    chk("t4_valid_held", rx_valid, 1);
    chk("t4_data_held", rx_data, 8'h01);
    chk("t4_oerr", n_over - o0, 1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_valid_cleared", rx_valid, 0);
    chk("t4_count", acc_q.size(), 1);
    chk("t4_acc_data", acc_q[0], 8'h01);
    @(posedge clk);
    #1;

    // ---------------- reset during data bit 4
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_bits(1);
    @(negedge clk);
    chk("t5_pre_valid", rx_valid, 1);
    @(posedge clk);
    #1;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    serial_in = d[4];
    repeat (BIT_CLK / 2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", rx_valid, 0);
    chk("t5_rst_data", rx_data, 0);
    chk("t5_rst_ferr", framing_err, 0);
    chk("t5_rst_oerr", overrun_err, 0);
    idle_bits(2);
    rx_ready = 1'b1;
    acc_q.delete();
    f0 = n_frame; o0 = n_over;
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(1);
    chk("t5_count", acc_q.size(), 1);
    chk("t5_data", acc_q[0], 8'h7E);
    chk("t5_ferr", n_frame - f0, 0);
    chk("t5_oerr", n_over - o0, 0);

`ifdef UART_RX_PARITY_EN
    // ---------------- parity
    acc_q.delete();
    p0 = n_par;
    send_frame(8'h07, 1'b1, 1'b1);   // parity bit 0: odd total
    idle_bits(1);
    chk("t6_bad_count", acc_q.size(), 1);
    chk("t6_bad_data", acc_q[0], 8'h07);
    chk("t6_bad_perr", n_par - p0, 1);
    acc_q.delete();
    p0 = n_par;
    send_frame(8'h07, 1'b1, 1'b0);   // parity bit 1: even total
    idle_bits(1);
    chk("t6_good_count", acc_q.size(), 1);
    chk("t6_good_perr", n_par - p0, 0);
`endif

    // ---------------- randomized frames against a word-level model
    acc_q.delete();
    exp_q.delete();
    f0 = n_frame; o0 = n_over; p0 = n_par;
    hold_v = 1'b0; hold_d = '0;
    exp_frame = 0; exp_over = 0; exp_par = 0;
    for (int k = 0; k < 24; k++) begin
      d   = WS'($urandom);
      r   = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      pf  = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      if (bad && gap == 0) gap = 1;
      ph  = $urandom_range(0, 3);
      if (ph > 0) begin
        repeat (ph) @(posedge clk);
        #1;
      end
      rx_ready = r;
      // A waiting word is taken as soon as the consumer becomes ready.
      if (r && hold_v) begin
        exp_q.push_back(hold_d);
        hold_v = 1'b0;
      end
      send_frame(d, !bad, pf);
      if (bad) begin
        exp_frame++;
      end else begin
`ifdef UART_RX_PARITY_EN
        if (pf) exp_par++;
`endif
        if (r) exp_q.push_back(d);
        else if (hold_v) exp_over++;
        else begin
          hold_v = 1'b1;
          hold_d = d;
        end
      end
      serial_in = 1'b1;
      idle_bits(gap);
    end
    rx_ready = 1'b1;
    if (hold_v) exp_q.push_back(hold_d);
    idle_bits(1);

    chk("rnd_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk($sformatf("rnd_word%0d", i), acc_q[i], exp_q[i]);
    chk("rnd_ferr", n_frame - f0, exp_frame);
    chk("rnd_oerr", n_over - o0, exp_over);
    chk("rnd_perr", n_par - p0, exp_par);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
